// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) -> magnitude (K-scaled) and atan2 phase in 2^32 = 360 deg units.
// Latency: result valid ITER clock edges after the accepting edge; one vector in flight, ITER+2 cycle throughput.
// Backpressure: in_ready only while IDLE; result held in DONE until out_ready, inputs ignored meanwhile.
module cordic_vectoring #(
    parameter int WIDTH = 16,
    parameter int ITER  = WIDTH - 1   // 1..30 micro-rotations
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH:0]          magnitude,
    output logic [31:0]             angle
);

    // Two guard bits: one for the -(-2^(WIDTH-1)) pre-rotation, one for the K growth.
    localparam int XW = WIDTH + 2;
    localparam int CW = 5;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          count;
    logic signed [XW-1:0]   x;
    logic signed [XW-1:0]   y;
    logic [31:0]            z;
    logic                   zero_vec;

    logic signed [XW-1:0]   xs;
    logic signed [XW-1:0]   ys;
    logic signed [XW-1:0]   x_rot;
    logic signed [XW-1:0]   y_rot;
    logic [31:0]            z_rot;
    logic signed [XW-1:0]   x_ext;
    logic signed [XW-1:0]   y_ext;

    // atan(2^-i) in 2^32 = 360 deg units, shared with the rotation-mode CORDIC.
    function automatic logic [31:0] atan_lut(input logic [CW-1:0] i);
        logic [31:0] r;
        case (i)
            5'd0:    r = 32'h20000000;
            5'd1:    r = 32'h12E4051D;
            5'd2:    r = 32'h09FB385B;
            5'd3:    r = 32'h051111D4;
            5'd4:    r = 32'h028B0D43;
            5'd5:    r = 32'h0145D7E1;
            5'd6:    r = 32'h00A2F61E;
            5'd7:    r = 32'h00517C55;
            5'd8:    r = 32'h0028BE53;
            5'd9:    r = 32'h00145F2F;
            5'd10:   r = 32'h000A2F98;
            5'd11:   r = 32'h000517CC;
            5'd12:   r = 32'h00028BE6;
            5'd13:   r = 32'h000145F3;
            5'd14:   r = 32'h0000A2FA;
            5'd15:   r = 32'h0000517D;
            5'd16:   r = 32'h000028BE;
            5'd17:   r = 32'h0000145F;
            5'd18:   r = 32'h00000A30;
            5'd19:   r = 32'h00000518;
            5'd20:   r = 32'h0000028C;
            5'd21:   r = 32'h00000146;
            5'd22:   r = 32'h000000A3;
            5'd23:   r = 32'h00000051;
            5'd24:   r = 32'h00000029;
            5'd25:   r = 32'h00000014;
            5'd26:   r = 32'h0000000A;
            5'd27:   r = 32'h00000005;
            5'd28:   r = 32'h00000003;
            5'd29:   r = 32'h00000001;
            5'd30:   r = 32'h00000001;
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

    // Arithmetic shift by i with round-half-up on the last bit shifted out.
    function automatic logic signed [XW-1:0] shift_round(input logic signed [XW-1:0] v,
                                                         input logic [CW-1:0] i);
        logic signed [XW-1:0] part;
        logic signed [XW-1:0] res;
        part = v >>> (i - 5'd1);
        if (i == '0) begin
            res = v;
        end else begin
            res = (part >>> 1) + $signed({{(XW-1){1'b0}}, part[0]});
        end
        return res;
    endfunction

    assign x_ext    = {{2{x_in[WIDTH-1]}}, x_in};
    assign y_ext    = {{2{y_in[WIDTH-1]}}, y_in};
    assign in_ready = rst_n && (state == IDLE);

    // One micro-rotation, steering y toward zero and accumulating the applied angle.
    always_comb begin
        xs = shift_round(x, count);
        ys = shift_round(y, count);
        if (!y[XW-1]) begin
            x_rot = x + ys;
            y_rot = y - xs;
            z_rot = z + atan_lut(count);
        end else begin
            x_rot = x - ys;
            y_rot = y + xs;
            z_rot = z - atan_lut(count);
        end
    end

    // Control FSM and datapath registers; results are registered on the final iteration.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            magnitude <= '0;
            angle     <= '0;
            count     <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            zero_vec  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Fold the left half-plane into the right so the iterations converge.
                        if (!x_in[WIDTH-1]) begin
                            x <= x_ext;
                            y <= y_ext;
                            z <= 32'h00000000;
                        end else if (!y_in[WIDTH-1]) begin
                            x <= y_ext;
                            y <= -x_ext;
                            z <= 32'h40000000;
                        end else begin
                            x <= -y_ext;
                            y <= x_ext;
                            z <= 32'hC0000000;
                        end
                        zero_vec <= (x_in == '0) && (y_in == '0);
                        count    <= '0;
                        state    <= ROTATE;
                    end
                end
                ROTATE: begin
                    x     <= x_rot;
                    y     <= y_rot;
                    z     <= z_rot;
                    count <= count + 5'd1;
                    if (count == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        // A zero vector has no defined phase; report exactly 0/0.
                        magnitude <= zero_vec ? '0 : x_rot[WIDTH:0];
                        angle     <= zero_vec ? 32'h0 : z_rot;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring: reset, axes, diagonals, zero vector, backpressure, abort.
// Expected results come from an ideal atan2/sqrt model with the stated error bounds.
// A scoreboard queue holds expectations from accept until the result handshake.
module tb_cordic_vectoring;

    localparam int WIDTH = 16;
    localparam int ITER  = 15;
    localparam real PI   = 3.14159265358979323846;

    logic                    clock = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH:0]          magnitude;
    logic [31:0]             angle;

    typedef struct {
        int          id;
        longint      mag;
        logic [31:0] ang;
        bit          exact;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    real  kgain;

    cordic_vectoring #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .magnitude (magnitude),
        .angle     (angle)
    );

    always #5 clock = ~clock;

    function automatic exp_t make_exp(input int id, input int xv, input int yv);
        exp_t   e;
        real    m;
        real    a;
        longint ai;
        m  = kgain * $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
        a  = $atan2(real'(yv), real'(xv)) * 4294967296.0 / (2.0 * PI);
        ai = longint'(a);
        if (ai < 0) ai = ai + 64'sd4294967296;
        e.id    = id;
        e.mag   = longint'(m);
        e.ang   = ai[31:0];
        e.exact = (xv == 0) && (yv == 0);
        return e;
    endfunction

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_tol(input string tag, input longint obs, input longint expv, input longint tol);
        longint d;
        d = obs - expv;
        if (d < 0) d = -d;
        total++;
        assert ((d <= tol) === 1'b1) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
        end
    endtask

    // Present a vector, wait (bounded) for acceptance; returns at the negedge after the accept edge.
    task automatic start_vec(input int id, input int xv, input int yv, input bit track);
        int n;
        n = 0;
        @(negedge clock);
        x_in     = xv[WIDTH-1:0];
        y_in     = yv[WIDTH-1:0];
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk_eq($sformatf("accept%0d", id), {63'd0, in_ready}, 64'd1);
        @(posedge clock);
        if (track) sb.push_back(make_exp(id, xv, yv));
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Count cycles to out_valid, then pop the scoreboard and compare.
    task automatic wait_result(input int id);
        int               lat;
        exp_t             e;
        logic signed [31:0] da;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        chk_eq($sformatf("latency%0d", id), 64'(lat), 64'(ITER));
        if (out_valid) begin
            chk_eq($sformatf("sb_nonempty%0d", id), {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.exact) begin
                    chk_eq($sformatf("mag%0d", id), 64'(magnitude), 64'(e.mag));
                    chk_eq($sformatf("ang%0d", id), 64'(angle), 64'(e.ang));
                end else begin
                    chk_tol($sformatf("mag%0d", id), longint'(magnitude), e.mag, 4);
                    da = angle - e.ang;
                    chk_tol($sformatf("ang%0d", id), longint'(da), 0, 131072);
                end
            end
        end
    endtask

    int vx[8] = '{16384, 0, -16384, 0, 10000, -10000, -32768, 0};
    int vy[8] = '{0, 16384, 0, -16384, 10000, -10000, -32768, 0};

    initial begin
        logic [WIDTH:0] m0;
        logic [31:0]    a0;
        int             rises;

        kgain = 1.0;
        for (int i = 0; i < ITER; i++) kgain = kgain * $sqrt(1.0 + $pow(2.0, -2.0 * i));

        // Reset with in_valid asserted
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        x_in      = 16'sd1000;
        y_in      = 16'sd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk_eq("rst_mag", 64'(magnitude), 64'd0);
        chk_eq("rst_ang", 64'(angle), 64'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        chk_eq("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk_eq("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

        // Axes, diagonals, full-scale corner, zero vector
        for (int k = 0; k < 8; k++) begin
            start_vec(k, vx[k], vy[k], 1'b1);
            wait_result(k);
        end

        // Backpressure: hold the result, offer a vector that must be ignored
        @(negedge clock);
        out_ready = 1'b0;
        start_vec(10, -20000, 7000, 1'b1);
        wait_result(10);
        m0       = magnitude;
        a0       = angle;
        x_in     = 16'sd1234;
        y_in     = 16'sd555;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk_eq("hold_valid", {63'd0, out_valid}, 64'd1);
            chk_eq("hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk_eq("hold_mag", 64'(magnitude), 64'(m0));
            chk_eq("hold_ang", 64'(angle), 64'(a0));
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clock);
        chk_eq("bp_release_valid", {63'd0, out_valid}, 64'd0);
        chk_eq("bp_release_ready", {63'd0, in_ready}, 64'd1);
        rises = 0;
        for (int c = 0; c < ITER + 4; c++) begin
            @(negedge clock);
            if (out_valid) rises++;
        end
        chk_eq("bp_no_spurious", 64'(rises), 64'd0);

        // Abort mid-rotation with reset
        start_vec(20, 12345, 6789, 1'b0);
        repeat (7) @(negedge clock);
        rst_n = 1'b0;
        @(negedge clock);
        chk_eq("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk_eq("abort_in_ready", {63'd0, in_ready}, 64'd0);
        chk_eq("abort_mag", 64'(magnitude), 64'd0);
        chk_eq("abort_ang", 64'(angle), 64'd0);
        rst_n = 1'b1;
        @(negedge clock);
        chk_eq("abort_idle", {63'd0, in_ready}, 64'd1);
        chk_eq("abort_idle_valid", {63'd0, out_valid}, 64'd0);
        start_vec(21, 3000, -4000, 1'b1);
        wait_result(21);
        @(negedge clock);
        chk_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
